// File: rtl/apb_master_stage.sv
// rtl/apb_master_stage.sv - APB master back-end: pops one request, runs one APB transfer, pushes one response
module apb_master_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         req_empty,
  input  logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8:0]  req_data,
  output logic                                         req_pop,
  input  logic                                         rsp_full,
  output logic                                         rsp_push,
  output logic [DATA_WIDTH+1:0]                        rsp_data,
  output logic [ADDR_WIDTH-1:0]                        paddr,
  output logic                                         psel,
  output logic                                         penable,
  output logic                                         pwrite,
  output logic [DATA_WIDTH-1:0]                        pwdata,
  output logic [DATA_WIDTH/8-1:0]                      pstrb,
  output logic [2:0]                                   pprot,
  input  logic [DATA_WIDTH-1:0]                        prdata,
  input  logic                                         pready,
  input  logic                                         pslverr,
  output logic                                         busy
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int REQ_W  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cnt;
  logic                   timeout_hit;
  logic                   req_write;
  logic [DATA_WIDTH-1:0]  rdata_sel;

  // cnt holds the number of not-ready cycles already spent, so the limit fires on the TIMEOUT-th one
  assign timeout_hit = (TIMEOUT != 0) && !pready && (cnt == CNT_LAST);
  assign req_write   = req_data[REQ_W-1];
  assign rdata_sel   = pwrite ? '0 : prdata;
  assign pprot       = 3'b000;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!req_empty) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
      RESP:    if (!rsp_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel     = (state == SETUP) || (state == ACCESS);
    penable  = (state == ACCESS);
    busy     = (state != IDLE);
    req_pop  = (state == IDLE) && !req_empty && !rst;
    rsp_push = (state == RESP) && !rsp_full && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      pstrb    <= '0;
      rsp_data <= '0;
      cnt      <= '0;
    end else begin
      if (req_pop) begin
        pwrite <= req_write;
        paddr  <= req_data[REQ_W-2 -: ADDR_WIDTH];
        pwdata <= req_write ? req_data[DATA_WIDTH+STRB_W-1 -: DATA_WIDTH] : '0;
        pstrb  <= req_write ? req_data[STRB_W-1:0] : '0;
      end
      if (state == SETUP)
        cnt <= '0;
      else if (state == ACCESS && !pready)
        cnt <= cnt + CW'(1);
      if (state == ACCESS) begin
        if (pready)
          rsp_data <= {pwrite, pslverr, rdata_sel};
        else if (timeout_hit)
          rsp_data <= {pwrite, 1'b1, {DATA_WIDTH{1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_apb_master_stage.sv
// tb/tb_apb_master_stage.sv - directed self-checking bench for apb_master_stage
module tb_apb_master_stage;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int RW = 1 + AW + DW + SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_empty;
  logic [RW-1:0] req_data;
  logic          req_pop;
  logic          rsp_full;
  logic          rsp_push;
  logic [DW+1:0] rsp_data;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic          busy;

  apb_master_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_empty(req_empty), .req_data(req_data), .req_pop(req_pop),
    .rsp_full(rsp_full), .rsp_push(rsp_push), .rsp_data(rsp_data), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  always #5 clk = ~clk;

  // request FIFO model: bench writes entries, DUT pops them
  logic [RW-1:0] req_mem [0:31];
  int wr_idx = 0;
  int rd_idx = 0;
  assign req_empty = (rd_idx == wr_idx);
  assign req_data  = req_mem[rd_idx[4:0]];
  always @(posedge clk) if (req_pop) rd_idx <= rd_idx + 1;

  logic [DW+1:0] rsp_mem [0:31];
  int rsp_cnt = 0;
  always @(posedge clk) if (rsp_push) begin
    rsp_mem[rsp_cnt[4:0]] <= rsp_data;
    rsp_cnt <= rsp_cnt + 1;
  end

  int acc_cnt = 0;
  always @(posedge clk) if (psel && penable) acc_cnt <= acc_cnt + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic xfer4;
    repeat (4) tick();
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_mem[wr_idx[4:0]] = {w, a, d, s};
    wr_idx++;
  endtask

  int a0, c0, p0, n;
  logic bad;

  initial begin
    rst = 1'b1; rsp_full = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();

    // reset state, with a request already queued
    push_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_busy", busy, 0);
    check("rst_req_pop", req_pop, 0);
    check("rst_rsp_push", rsp_push, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", {pwrite, pstrb, pwdata}, 0);
    check("pprot", pprot, 0);
    tick();
    rst = 1'b0; pready = 1'b1;
    #1;
    check("wr_pop", req_pop, 1);

    // single write, minimum latency
    tick();
    check("wr_setup", {psel, penable}, 2'b10);
    check("wr_paddr", paddr, 32'h10);
    check("wr_pwrite", pwrite, 1);
    check("wr_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_pstrb", pstrb, 4'hF);
    tick();
    check("wr_access", {psel, penable}, 2'b11);
    tick();
    check("wr_push", rsp_push, 1);
    check("wr_resp_psel", psel, 0);
    check("wr_rsp", rsp_data, {1'b1, 1'b0, 32'h0});
    tick();
    check("wr_idle_busy", busy, 0);
    check("wr_rsp_cnt", rsp_cnt, 1);

    // read with 3 wait states; write data/strobes must be forced to 0
    pready = 1'b0;
    push_req(1'b0, 32'h24, 32'h11111111, 4'hF);
    tick();
    a0 = acc_cnt;
    check("rd_paddr", paddr, 32'h24);
    check("rd_pwdata", {pwrite, pstrb, pwdata}, 0);
    repeat (4) tick();
    pready = 1'b1; prdata = 32'hCAFEF00D;
    tick();
    check("rd_acc_cycles", acc_cnt - a0, 4);
    check("rd_push", rsp_push, 1);
    check("rd_rsp", rsp_data, {1'b0, 1'b0, 32'hCAFEF00D});
    tick();

    // slave error
    pslverr = 1'b1; prdata = 32'h55;
    push_req(1'b0, 32'h30, 32'h0, 4'h0);
    repeat (3) tick();
    check("err_rsp", rsp_data, {1'b0, 1'b1, 32'h55});
    tick();
    pslverr = 1'b0;

    // timeout: 16 not-ready ACCESS cycles then error response
    pready = 1'b0;
    push_req(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    a0 = acc_cnt; n = 0;
    while (psel && n < 40) begin tick(); n++; end
    check("to_bound", n < 40, 1);
    check("to_acc_cycles", acc_cnt - a0, 16);
    check("to_push", rsp_push, 1);
    check("to_rsp", rsp_data, {1'b0, 1'b1, 32'h0});
    tick();

    // pready arrives in the 16th ACCESS cycle: normal completion wins
    push_req(1'b0, 32'h44, 32'h0, 4'h0);
    tick();
    a0 = acc_cnt;
    repeat (16) tick();
    pready = 1'b1; prdata = 32'hABCD;
    tick();
    check("edge_acc_cycles", acc_cnt - a0, 16);
    check("edge_rsp", rsp_data, {1'b0, 1'b0, 32'hABCD});
    tick();

    // request after the timeout path completes normally
    prdata = 32'h1234;
    push_req(1'b0, 32'h48, 32'h0, 4'h0);
    repeat (3) tick();
    check("post_to_rsp", rsp_data, {1'b0, 1'b0, 32'h1234});
    tick();

    // backpressure and ordering with three queued reads
    c0 = rsp_cnt; p0 = rd_idx;
    push_req(1'b0, 32'h60, 32'h0, 4'h0);
    push_req(1'b0, 32'h64, 32'h0, 4'h0);
    push_req(1'b0, 32'h68, 32'h0, 4'h0);
    prdata = 32'hA1;
    tick(); tick();
    rsp_full = 1'b1;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bad |= rsp_push | psel | req_pop | !busy;
      if (i < 4) tick();
    end
    check("bp_stall", bad, 0);
    check("bp_one_pop", rd_idx - p0, 1);
    rsp_full = 1'b0;
    #1;
    check("bp_push", rsp_push, 1);
    prdata = 32'hA2;
    tick();
    xfer4();
    prdata = 32'hA3;
    xfer4();
    check("bp_rsp_cnt", rsp_cnt - c0, 3);
    check("bp_rsp0", rsp_mem[c0[4:0]], {1'b0, 1'b0, 32'hA1});
    check("bp_rsp1", rsp_mem[5'(c0 + 1)], {1'b0, 1'b0, 32'hA2});
    check("bp_rsp2", rsp_mem[5'(c0 + 2)], {1'b0, 1'b0, 32'hA3});

    // reset during ACCESS drops the request
    pready = 1'b0;
    push_req(1'b0, 32'h70, 32'h0, 4'h0);
    tick(); tick(); tick();
    rst = 1'b1;
    c0 = rsp_cnt;
    tick();
    check("mid_rst_psel", {psel, penable}, 2'b00);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("mid_rst_no_rsp", rsp_cnt - c0, 0);
    pready = 1'b1;
    push_req(1'b1, 32'h74, 32'h0000BEEF, 4'h1);
    tick();
    check("after_rst_paddr", paddr, 32'h74);
    check("after_rst_pstrb", pstrb, 4'h1);
    tick(); tick();
    check("after_rst_rsp", rsp_data, {1'b1, 1'b0, 32'h0});
    tick();
    check("after_rst_rsp_cnt", rsp_cnt - c0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_stage.md
# apb_master_stage

APB master back-end of the APB/AXI4-Lite bridge. It sits directly downstream of the request FIFO and upstream of the response FIFO. It pops one queued request, runs one APB3/APB4 transfer (SETUP, then ACCESS until PREADY) and pushes the result word into the response FIFO. A programmable PREADY timeout guarantees the bridge never hangs on a dead slave.

## Interface
Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; must be a multiple of 8.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before forced error; 0 disables the timeout.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_empty  in  1  request FIFO empty.
- req_data  in  1+ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8  show-ahead head word {write, addr, wdata, strb}, MSB first; valid while req_empty=0.
- req_pop  out  1  consume head of request FIFO.
- rsp_full  in  1  response FIFO full.
- rsp_push  out  1  write rsp_data into response FIFO.
- rsp_data  out  2+DATA_WIDTH  {write, slverr, rdata}.
- paddr  out  ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB write strobes.
- pprot  out  3  constant 3'b000.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.
- busy  out  1  high in any state other than IDLE.

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP.

IDLE
- req_pop = (state==IDLE) && !req_empty, combinational.
- On a pop edge: register write/addr/wdata/strb into paddr, pwrite, pwdata, pstrb, then go to SETUP.
- For reads, force pwdata=0 and pstrb=0.

SETUP
- psel=1, penable=0.
- Unconditional transition to ACCESS.

ACCESS
- psel=1, penable=1; APB signals stay stable.
- If pready=1: capture rdata=(pwrite?0:prdata) and slverr=pslverr into rsp_data, then go to RESP.
- Timeout counter (width $clog2(TIMEOUT+1)) is cleared on entry and increments each ACCESS cycle with pready=0.
- When TIMEOUT≠0 and the counter reaches TIMEOUT (TIMEOUT consecutive not-ready cycles): go to RESP with slverr=1 and rdata=0.
- pready=1 in the same cycle the limit is hit: pready wins, normal response.

RESP
- psel=0, penable=0.
- rsp_push = (state==RESP) && !rsp_full, combinational; rsp_data is held stable while rsp_full=1.
- Go to IDLE on the push edge.

Other rules
- Exactly one APB transfer and exactly one response per popped request; order is preserved.
- Only one request is ever outstanding.
- pprot is constant 0.

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, rsp_data=0, busy=0, state=IDLE.
- With rsp_full=0, req_pop and rsp_push are 0 during and after reset.
- Minimum latency with pready high at first ACCESS:
  - cycle 0: pop.
  - cycle 1: SETUP.
  - cycle 2: ACCESS.
  - cycle 3: RESP push.
  - cycle 4: IDLE, may pop again.
- Peak throughput: 1 transfer / 4 cycles.
- Each pready-low cycle adds one ACCESS cycle.
- Timeout path: RESP is reached after TIMEOUT not-ready ACCESS cycles; push follows in the RESP cycle.
- rsp_full stalls RESP indefinitely with psel=0; no new pop occurs while stalled.
- Reset mid-transfer: the next edge returns to IDLE with psel/penable=0. The in-flight request is dropped, no response is pushed, and the counter is cleared.
- req_data is sampled only on the pop edge; later changes are ignored.

## Test plan
- Single write: req {1, 0x10, 0xDEADBEEF, 4'hF}, pready=1 -> SETUP then ACCESS with paddr=0x10, pwrite=1, pwdata=0xDEADBEEF, pstrb=F; cycle 3 rsp_push with rsp_data={1,0,0}.
- Read with wait states: req {0, 0x24, x, x}, pready low 3 ACCESS cycles then high with prdata=0xCAFEF00D -> 4 ACCESS cycles, pwdata=0, pstrb=0; rsp_data={0,0,0xCAFEF00D}.
- Slave error: read with pready=1, pslverr=1, prdata=0x55 -> rsp_data={0,1,0x55}.
- Timeout: TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then psel=0; rsp_data={0,1,0}; a later request completes normally.
- Backpressure and ordering: 3 queued requests, rsp_full=1 for 5 cycles during the first RESP -> rsp_push is held off and no second pop occurs until the push; all 3 responses arrive in order.
- Reset mid-ACCESS (pready=0): assert rst 1 cycle -> psel=0 next edge, no rsp_push, busy=0; the next popped request runs cleanly.
